// File: rtl/riskproc_pkg.sv
// Shared decode constants for the integer core and the encoding of the
// multiply/divide sequencer state.
package riskproc_pkg;

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  localparam logic [6:0] R_type = 7'b0110011;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift/add multiplier (mode=0) or the restoring
// divider (mode=1) over a 2*XLEN {high:low} working register.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic                mode,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     opnd,
  output logic [2*XLEN-1:0]   acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    trial    = rem_sh - {1'b0, opnd};
    acc_next = {sum, acc[XLEN-1:1]};
    // The trial fits in XLEN+1 bits because the partial remainder stays below the divisor.
    if (mode) begin
      if (!trial[XLEN]) acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else              acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide/remainder unit with valid/ready handshake,
// fixed latency, flush, and special-case bypass for /0 and signed overflow.
module muldiv_seq
  import riskproc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN + 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            f3;
  logic [TAG_W-1:0]      tag;
  logic                  neg;
  logic [2*XLEN-1:0]     acc;
  logic [2*XLEN-1:0]     acc_next;
  logic [XLEN-1:0]       opnd;

  logic                  sa, sb, neg_in, special;
  logic [XLEN-1:0]       mag_a, mag_b, spec_res;

  always_comb begin
    sa      = (in_funct3 inside {MULH, MULHSU, DIV, REM}) && in_a[XLEN-1];
    sb      = (in_funct3 inside {MULH, DIV, REM}) && in_b[XLEN-1];
    mag_a   = sa ? (~in_a + 1'b1) : in_a;
    mag_b   = sb ? (~in_b + 1'b1) : in_b;
    // Remainder follows the dividend sign; everything else follows the sign product.
    neg_in  = (is_div_op(in_funct3) && in_funct3[1]) ? sa : (sa ^ sb);
    special = 1'b0;
    spec_res = '0;
    if (is_div_op(in_funct3)) begin
      if (in_b == '0) begin
        special  = 1'b1;
        spec_res = in_funct3[1] ? in_a : '1;
      end else if ((in_funct3 == DIV || in_funct3 == REM) &&
                   in_a == {1'b1, {(XLEN-1){1'b0}}} && in_b == '1) begin
        special  = 1'b1;
        spec_res = in_funct3[1] ? '0 : in_a;
      end
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode     (is_div_op(f3)),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  function automatic logic [XLEN-1:0] fix_result(input logic [2:0] op, input logic n,
                                                 input logic [2*XLEN-1:0] a);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   r;
    if (!is_div_op(op)) begin
      p = n ? (~a + 1'b1) : a;
      return (op == MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end
    r = op[1] ? a[2*XLEN-1:XLEN] : a[XLEN-1:0];
    return n ? (~r + 1'b1) : r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          f3       <= in_funct3;
          tag      <= in_tag;
          neg      <= neg_in;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          if (special) begin
            out_result <= spec_res;
            out_tag    <= in_tag;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            acc   <= {{XLEN{1'b0}}, mag_a};
            opnd  <= mag_b;
            cnt   <= CNT_W'(XLEN);
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          out_result <= fix_result(f3, neg, acc);
          out_tag    <= tag;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed scoreboard bench for muldiv_seq: the driver queues expected
// result/tag/latency, a negedge monitor pops on each rising out_valid.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic        in_ready, out_valid, busy;
  logic [2:0]  in_funct3;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every rising out_valid must match the oldest queued request.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("result_tag%0d", e.tag), out_result, e.res);
        check($sformatf("tag_tag%0d", e.tag), 32'(out_tag), 32'(e.tag));
        check($sformatf("cycle_tag%0d", e.tag), 32'(cyc - e.acc_cyc + 1), 32'(e.lat + 1));
      end
    end
    ov_prev = out_valid;
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg, input logic [31:0] exp, input int lat,
                       input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_funct3 = f; in_a = a; in_b = b; in_tag = tg;
    if (push) q.push_back('{exp, tg, cyc + 1, lat});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && !out_valid) && n < 100) begin @(negedge clk); n++; end
    if (!(in_ready && !out_valid)) check("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r_hold;
    logic [4:0]  t_hold;
    int          n;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_funct3 = 3'd0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_out_tag", 32'(out_tag), 32'd0);

    issue(3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33, 1); wait_idle();
    issue(3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33, 1); wait_idle();
    issue(3'd3, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, 33, 1); wait_idle();
    issue(3'd2, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, 33, 1); wait_idle();
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 33, 1); wait_idle();
    issue(3'd5, 32'd100,      32'd7,        5'd6,  32'd14,       33, 1); wait_idle();
    issue(3'd7, 32'd100,      32'd7,        5'd7,  32'd2,        33, 1); wait_idle();
    issue(3'd4, 32'hFFFFFF9C, 32'd7,        5'd8,  32'hFFFFFFF2, 33, 1); wait_idle();
    issue(3'd6, 32'hFFFFFF9C, 32'd7,        5'd9,  32'hFFFFFFFE, 33, 1); wait_idle();
    issue(3'd4, 32'd100,      32'hFFFFFFF9, 5'd10, 32'hFFFFFFF2, 33, 1); wait_idle();
    issue(3'd6, 32'd100,      32'hFFFFFFF9, 5'd11, 32'd2,        33, 1); wait_idle();
    issue(3'd4, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 0,  1); wait_idle();
    issue(3'd6, 32'd5,        32'd0,        5'd13, 32'd5,        0,  1); wait_idle();
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 0,  1); wait_idle();
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        0,  1); wait_idle();
    issue(3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        33, 1); wait_idle();

    // Back-pressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 5'd17, 32'd14, 33, 1);
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    r_hold = out_result; t_hold = out_tag;
    repeat (5) begin
      @(negedge clk);
      check("bp_result_stable", out_result, 32'd14);
      check("bp_tag_stable", 32'(out_tag), 32'd17);
      check("bp_out_valid_held", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    check("bp_hold_match", out_result, r_hold);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Flush mid-run with a competing request: nothing may come out.
    issue(3'd0, 32'h1234, 32'd5, 5'd18, 32'd0, 0, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_funct3 = 3'd0; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd19;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 5'd20, 32'd12, 33, 1); wait_idle();

    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide/remainder operations. It replaces the single-cycle `*`, `/` and `%` paths with an iterative shift/add/subtract engine and exposes a valid/ready handshake. The decode/issue stage sees a stall while an operation is in flight. It sits beside the integer ALU, receives the same operand buses and funct3, and writes back through the normal result path with a destination tag.

## Interface
- `XLEN`, 32: operand and result width.
- `TAG_W`, 5: width of the writeback tag (rd index) carried through.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  high only in IDLE.
- `in_funct3`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `in_a`, `in_b`  in  XLEN  rs1/rs2 operands.
- `in_tag`  in  TAG_W  destination tag.
- `flush`  in  1  abort the in-flight or pending operation.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  XLEN  result.
- `out_tag`  out  TAG_W  tag of the result.
- `busy`  out  1  high in any state other than IDLE; drives the issue stall.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Reset values: IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `out_result`=0, `out_tag`=0, iteration counter 0.
- IDLE: when `in_valid`&&`in_ready`, latch funct3, tag and the operand signs.
  - Operands are converted to magnitudes. `in_a` is treated as signed for MULH, MULHSU, DIV and REM. `in_b` is treated as signed for MULH, DIV and REM.
  - Result negation flag:
    - multiply: set when the signs differ.
    - DIV: set when the signs differ.
    - REM: set when the dividend is negative.
- Special cases go IDLE -> DONE directly, without running the engine:
  - Divide by zero (`in_b`==0): DIV/DIVU give all-ones; REM/REMU give `in_a`.
  - Signed overflow (DIV/REM, `in_a`=0x80000000, `in_b`=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Otherwise IDLE -> RUN with counter = XLEN.
- RUN, multiply: one shift-add step per cycle on a 2·XLEN accumulator.
- RUN, divide: one restoring-division step per cycle; 2·XLEN remainder:quotient register.
- RUN: the counter decrements each cycle. At counter==1 the next state is FIX.
- FIX: apply two's-complement negation if the flag is set. Select the result:
  - MUL: low XLEN bits.
  - MULH, MULHSU, MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Then go to DONE.
- DONE: `out_valid`=1 with `out_result`/`out_tag` stable until `out_valid`&&`out_ready`, then go to IDLE. No new request is accepted in the same cycle as the handoff.
- `flush`: from any state, next state is IDLE and `out_valid` drops next cycle. Flush has priority over a simultaneous `in_valid` (not accepted) and over a simultaneous `out_ready` (the result is discarded).
- `reset` has priority over `flush`.
- Width rule: all internal arithmetic is XLEN+1 bits or 2·XLEN bits; no truncation before FIX.

## Timing
- Accept on edge 0.
- Normal operation: RUN occupies cycles 1..XLEN, FIX occupies cycle XLEN+1, and `out_valid` rises at cycle XLEN+2 (34 for XLEN=32).
- Special case: `out_valid` rises at cycle 1.
- Latency is independent of operand values; there is no early termination.
- `in_ready` is low from the cycle after acceptance until the cycle after the result handoff.
- `busy` = !IDLE, registered from state.
- Throughput: one operation per XLEN+3 cycles with `out_ready` tied high.

## Structure
- Shared package `riskproc_pkg`:
  - funct3 constants MUL…REMU (shared with the ALU decode).
  - the opcode constant `R_type`.
  - the state encoding.
- Sub-module `muldiv_step`: combinational single-iteration datapath (add-or-skip / subtract-and-restore), selected by a mode bit.
- FSM, counter, sign handling and output registers live in `muldiv_seq`.

## Test plan
- MUL 7 × 0xFFFFFFFD -> 0xFFFFFFEB, `out_valid` at cycle 34, tag echoed.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14, REMU -> 2; DIV 0xFFFFFF9C (−100)/7 -> 0xFFFFFFF2, REM -> 0xFFFFFFFE.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both at cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, at cycle 1.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE -> result and tag stable, `in_ready`=0, `busy`=1. Release -> IDLE next cycle.
- Flush at RUN cycle 10 with `in_valid` high -> no `out_valid`, `in_ready`=1 next cycle, and a fresh MUL 3×4 then returns 12.
